acc_writeback_dma: RTL and testbench

ACC_WRITEBACK_DMA -- requirements
Module: acc_writeback_dma

---
 rtl/acc_writeback_dma_if.sv | 33 +++
 rtl/acc_writeback_dma.sv | 93 +++++++++
 tb/tb_acc_writeback_dma.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_writeback_dma_if.sv
// Bus bundle for the accelerator write-back DMA: CPU control/status,
// accelerator read port and memory write port.
interface acc_writeback_dma_if;
  logic        start_transfer;
  logic        abort;
  logic [31:0] src_addr;
  logic [31:0] dest_addr;
  logic [31:0] transfer_length;
  logic        dma_busy;
  logic        dma_done;
  logic [31:0] words_done;
  logic [31:0] acc_addr;
  logic        acc_read;
  logic [31:0] acc_data_in;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_data_out;
  logic        mem_ready;

  modport master (
    input  start_transfer, abort, src_addr, dest_addr, transfer_length,
    input  acc_data_in, mem_ready,
    output dma_busy, dma_done, words_done,
    output acc_addr, acc_read, mem_addr, mem_write, mem_data_out
  );

  modport slave (
    output start_transfer, abort, src_addr, dest_addr, transfer_length,
    output acc_data_in, mem_ready,
    input  dma_busy, dma_done, words_done,
    input  acc_addr, acc_read, mem_addr, mem_write, mem_data_out
  );
endinterface

// File: rtl/acc_writeback_dma.sv
// Word-by-word copy from accelerator memory to system memory: read one word,
// wait one cycle for the data, write it and hold until memory accepts.
module acc_writeback_dma (
  input logic             clk,
  input logic             reset,
  acc_writeback_dma_if.master bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] src_cur, dst_cur, src_nxt, dst_nxt;
  logic [29:0] cnt_left, cnt_nxt;
  logic        start_ok, cancel, accept;
  logic        unused_len_bits;

  assign unused_len_bits = ^bus.transfer_length[1:0];

  always_comb begin
    start_ok  = (state == IDLE) && bus.start_transfer && !bus.dma_busy;
    cancel    = bus.abort && (state != IDLE);
    // abort wins over a same-cycle acceptance: that word is not counted
    accept    = (state == WRITE) && bus.mem_ready && !bus.abort;
    src_nxt   = src_cur;
    dst_nxt   = dst_cur;
    cnt_nxt   = cnt_left;
    state_nxt = state;

    if (start_ok) begin
      src_nxt = bus.src_addr;
      dst_nxt = bus.dest_addr;
      cnt_nxt = bus.transfer_length[31:2];
    end else if (accept) begin
      src_nxt = src_cur + 32'd4;
      dst_nxt = dst_cur + 32'd4;
      cnt_nxt = cnt_left - 30'd1;
    end

    case (state)
      IDLE:    if (start_ok) state_nxt = (cnt_nxt == 30'd0) ? DONE : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = WRITE;
      WRITE:   if (accept) state_nxt = (cnt_nxt == 30'd0) ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (cancel) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Working pointers are only consulted after a start has loaded them.
  always_ff @(posedge clk) begin
    src_cur  <= src_nxt;
    dst_cur  <= dst_nxt;
    cnt_left <= cnt_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.dma_busy     <= 1'b0;
      bus.dma_done     <= 1'b0;
      bus.words_done   <= 32'd0;
      bus.acc_addr     <= 32'd0;
      bus.acc_read     <= 1'b0;
      bus.mem_addr     <= 32'd0;
      bus.mem_write    <= 1'b0;
      bus.mem_data_out <= 32'd0;
    end else begin
      bus.acc_read  <= (state_nxt == ISSUE);
      bus.mem_write <= (state_nxt == WRITE);
      if (state_nxt == ISSUE) bus.acc_addr <= src_nxt;
      if ((state == WAIT) && (state_nxt == WRITE)) begin
        bus.mem_addr     <= dst_cur;
        bus.mem_data_out <= bus.acc_data_in;
      end

      // The completion pulse is registered on leaving DONE; busy stays up
      // through the pulse cycle and drops together with it.
      bus.dma_done <= (state == DONE) && !cancel;
      if (start_ok)                     bus.dma_busy <= 1'b1;
      else if (cancel || bus.dma_done)  bus.dma_busy <= 1'b0;

      if (start_ok)    bus.words_done <= 32'd0;
      else if (accept) bus.words_done <= bus.words_done + 32'd1;
    end
  end

endmodule

// File: tb/tb_acc_writeback_dma.sv
// Scoreboard bench: expected memory writes are queued at start and popped
// as the memory port accepts them; accelerator and memory are modelled here.
module tb_acc_writeback_dma;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  acc_writeback_dma_if bus();
  acc_writeback_dma dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];

  int cyc = 0;
  int n_reads, n_writes, n_done, n_hits, n_busy, w0_cyc, first_rd, done_at;
  logic [31:0] w0_addr;
  bit          pend;
  logic [31:0] p_addr, p_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] acc_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic clr_stats();
    n_reads = 0; n_writes = 0; n_done = 0; n_hits = 0; n_busy = 0;
    w0_cyc = 0; first_rd = -1; done_at = -1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Accelerator: word for the address read appears the cycle after acc_read.
  initial begin
    bus.acc_data_in = 32'd0;
    forever begin
      @(negedge clk);
      if (bus.acc_read) bus.acc_data_in = acc_word(bus.acc_addr);
    end
  end

  // Memory-side monitor and scoreboard.
  initial begin
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus.dma_busy) n_busy++;
        if (bus.acc_read) begin
          n_reads++;
          if (first_rd < 0) first_rd = cyc;
        end
        if (bus.dma_done) begin
          n_done++;
          done_at = cyc;
        end
        if (bus.mem_write) begin
          if (pend) begin
            chk("hold_addr", bus.mem_addr, p_addr);
            chk("hold_data", bus.mem_data_out, p_data);
          end
          if (bus.mem_addr == w0_addr) w0_cyc++;
          if (bus.mem_ready && bus.abort) n_hits++;
          pend   = !(bus.mem_ready && !bus.abort);
          p_addr = bus.mem_addr;
          p_data = bus.mem_data_out;
          if (bus.mem_ready && !bus.abort) begin
            n_writes++;
            if (exp_addr.size() == 0) begin
              chk("unexpected_write", bus.mem_addr, 32'hFFFF_FFFF);
            end else begin
              chk("wr_addr", bus.mem_addr, exp_addr.pop_front());
              chk("wr_data", bus.mem_data_out, exp_data.pop_front());
            end
          end
        end else begin
          pend = 1'b0;
        end
      end else begin
        pend = 1'b0;
      end
    end
  end

  // Called at posedge+2; leaves at posedge+2 of the cycle after acceptance.
  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    logic [31:0] off;
    bus.src_addr        = s;
    bus.dest_addr       = d;
    bus.transfer_length = l;
    bus.start_transfer  = 1'b1;
    for (int i = 0; i < int'(l[31:2]); i++) begin
      off = 32'(i) * 32'd4;
      exp_addr.push_back(d + off);
      exp_data.push_back(acc_word(s + off));
    end
    @(posedge clk); #2;
    bus.start_transfer = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    bit idle = 1'b0;
    for (int i = 0; i < max && !idle; i++) begin
      @(negedge clk);
      if (!bus.dma_busy) idle = 1'b1;
    end
    chk(tag, 32'(idle), 32'd1);
    @(posedge clk); #2;
  endtask

  task automatic wait_write(input string tag, input int max, input int wd);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_write && bus.words_done == 32'(wd)) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs;
    reset = 1'b0;
    bus.start_transfer = 1'b0; bus.abort = 1'b0;
    bus.src_addr = 32'd0; bus.dest_addr = 32'd0; bus.transfer_length = 32'd0;
    bus.mem_ready = 1'b1;
    w0_addr = 32'hFFFF_FFF0;
    clr_stats();

    @(negedge clk);
    chk("rst_busy", 32'(bus.dma_busy), 32'd0);
    chk("rst_done", 32'(bus.dma_done), 32'd0);
    chk("rst_acc_read", 32'(bus.acc_read), 32'd0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_words_done", bus.words_done, 32'd0);
    chk("rst_acc_addr", bus.acc_addr, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_data", bus.mem_data_out, 32'd0);

    // three words, start driven as reset releases
    @(posedge clk); #2;
    reset = 1'b1;
    clr_stats();
    cs = cyc;
    start_xfer(32'h100, 32'h2000, 32'd12);
    wait_idle("basic_idle", 40);
    chk("basic_first_start", 32'(first_rd), 32'(cs + 1));
    chk("basic_reads", 32'(n_reads), 32'd3);
    chk("basic_writes", 32'(n_writes), 32'd3);
    chk("basic_done_pulses", 32'(n_done), 32'd1);
    chk("basic_words_done", bus.words_done, 32'd3);
    // DONE is entered 9 cycles after ISSUE; the registered pulse follows it
    chk("basic_issue_to_pulse", 32'(done_at - first_rd), 32'd10);
    chk("basic_sb_empty", 32'(exp_addr.size()), 32'd0);

    for (int k = 0; k < 2; k++) begin
      clr_stats();
      start_xfer(32'h180, 32'h2100, (k == 0) ? 32'd0 : 32'd3);
      wait_idle("zero_idle", 20);
      chk("zero_reads", 32'(n_reads), 32'd0);
      chk("zero_writes", 32'(n_writes), 32'd0);
      chk("zero_busy_cycles", 32'(n_busy), 32'd2);
      chk("zero_done_pulses", 32'(n_done), 32'd1);
      chk("zero_words_done", bus.words_done, 32'd0);
    end

    // back-pressure on word 0 for five cycles
    bus.mem_ready = 1'b0;
    clr_stats();
    w0_addr = 32'h3000;
    start_xfer(32'h400, 32'h3000, 32'd8);
    wait_write("stall_seen", 20, 0);
    repeat (5) @(posedge clk);
    #2;
    bus.mem_ready = 1'b1;
    wait_idle("stall_idle", 40);
    chk("stall_w0_cycles", 32'(w0_cyc), 32'd6);
    chk("stall_writes", 32'(n_writes), 32'd2);
    chk("stall_words_done", bus.words_done, 32'd2);
    chk("stall_done_pulses", 32'(n_done), 32'd1);
    w0_addr = 32'hFFFF_FFF0;

    // address wrap on both pointers
    clr_stats();
    start_xfer(32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd8);
    wait_idle("wrap_idle", 40);
    chk("wrap_writes", 32'(n_writes), 32'd2);
    chk("wrap_sb_empty", 32'(exp_addr.size()), 32'd0);

    // abort with mem_ready on the second write; a stray start in between
    clr_stats();
    start_xfer(32'h500, 32'h4000, 32'd16);
    @(posedge clk); #2;
    bus.src_addr = 32'h9000; bus.dest_addr = 32'h7000; bus.transfer_length = 32'd40;
    bus.start_transfer = 1'b1;
    @(posedge clk); #2;
    bus.start_transfer = 1'b0;
    repeat (3) begin @(posedge clk); #2; end
    bus.abort = 1'b1;
    @(posedge clk); #2;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.dma_busy), 32'd0);
    chk("abort_mem_write", 32'(bus.mem_write), 32'd0);
    chk("abort_acc_read", 32'(bus.acc_read), 32'd0);
    chk("abort_words_done", bus.words_done, 32'd1);
    chk("abort_collision", 32'(n_hits), 32'd1);
    chk("abort_writes", 32'(n_writes), 32'd1);
    chk("abort_sb_left", 32'(exp_addr.size()), 32'd3);
    exp_addr.delete(); exp_data.delete();
    repeat (4) @(negedge clk);
    chk("abort_no_done", 32'(n_done), 32'd0);
    chk("abort_reads", 32'(n_reads), 32'd2);
    chk("abort_words_hold", bus.words_done, 32'd1);

    // asynchronous reset during the second write
    @(posedge clk); #2;
    clr_stats();
    start_xfer(32'h600, 32'h5000, 32'd16);
    wait_write("rst_write_seen", 20, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("rstmid_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rstmid_busy", 32'(bus.dma_busy), 32'd0);
    chk("rstmid_words_done", bus.words_done, 32'd0);
    exp_addr.delete(); exp_data.delete();
    @(posedge clk); #2;
    reset = 1'b1;
    bus.abort = 1'b1;
    clr_stats();
    cs = cyc;
    start_xfer(32'h700, 32'h6000, 32'd4);
    bus.abort = 1'b0;
    wait_idle("restart_idle", 20);
    chk("restart_first_start", 32'(first_rd), 32'(cs + 1));
    chk("restart_writes", 32'(n_writes), 32'd1);
    chk("restart_words_done", bus.words_done, 32'd1);
    chk("restart_done_pulses", 32'(n_done), 32'd1);
    chk("restart_sb_empty", 32'(exp_addr.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
